// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// master: controller side (samples opcode/zero/mem_ready, drives every mux select and enable).
// slave:  datapath side.
//   opcode[5:0]    IR[31:26]
//   zero           ALU zero flag
//   mem_ready      memory access complete
//   pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a shared multicycle MIPS datapath (R-type, lw, sw, beq, j, addi).
// Undefined opcodes park the FSM in a sticky trap state. Also counts retired instructions.
// Optional feature macro: MEM_WAIT_EN -- memory states stall until mem_ready.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   bus          multicycle_control_if.master control bus
//   state        current state encoding (debug)
//   illegal      sticky undefined-opcode flag
//   instr_count  retired-instruction counter, wraps
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_if.master     bus,
  output logic [3:0]               state,
  output logic                     illegal,
  output logic [CNT_W-1:0]         instr_count
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiEx   = 4'd10,
    StAddiWb   = 4'd11,
    StReset    = 4'd14,
    StTrap     = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_e            state_q, state_d;
  ctrl_t             ctrl_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  count_q;
  logic              retire;
  logic              mem_done;

  // Moore decode; applied to the next state so the control register lines up with state_q.
  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      StDecode:  c.alu_src_b = 2'b11;
      StMemAddr, StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRead: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      StExec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      StRWb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      StAddiWb:  c.reg_write = 1'b1;
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: ;
    endcase
    return c;
  endfunction

`ifdef MEM_WAIT_EN
  assign mem_done = bus.mem_ready;
`else
  assign mem_done = 1'b1;
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:    state_d = StFetch;
      StFetch:    if (mem_done) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          6'b000000:            state_d = StExec;
          6'b100011, 6'b101011: state_d = StMemAddr;
          6'b000100:            state_d = StBranch;
          6'b000010:            state_d = StJump;
          6'b001000:            state_d = StAddiEx;
          default:              state_d = StTrap;
        endcase
      end
      // lw and sw differ only in opcode bit 3.
      StMemAddr:  state_d = bus.opcode[3] ? StMemWrite : StMemRead;
      StMemRead:  if (mem_done) state_d = StMemWb;
      StMemWrite: if (mem_done) state_d = StFetch;
      StExec:     state_d = StRWb;
      StAddiEx:   state_d = StAddiWb;
      StMemWb, StRWb, StAddiWb, StBranch, StJump: state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
  end

  // An instruction retires when a terminal state hands back to FETCH.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StMemWb, StMemWrite, StRWb, StAddiWb, StBranch, StJump: retire = (state_d == StFetch);
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StReset;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
      if (state_d == StTrap) illegal_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  logic pc_write_w;
  logic ir_write_w;

`ifdef MEM_WAIT_EN
  // Fetch only commits IR/PC in the cycle the memory completes.
  assign pc_write_w = ctrl_q.pc_write & ((state_q != StFetch) | bus.mem_ready);
  assign ir_write_w = ctrl_q.ir_write & bus.mem_ready;
`else
  assign pc_write_w = ctrl_q.pc_write;
  assign ir_write_w = ctrl_q.ir_write;
`endif

  assign bus.pc_write      = pc_write_w;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.pc_en         = pc_write_w | (ctrl_q.pc_write_cond & bus.zero);
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.ir_write      = ir_write_w;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.pc_source     = ctrl_q.pc_source;

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of per-cycle vectors plus hand-written
// sequences for trap hold, mid-instruction reset, memory wait and counter wrap (CNT_W=4).
module tb_multicycle_control;

  logic clk;
  logic rst;
  logic rst4;

  multicycle_control_if bus ();
  multicycle_control_if bus4 ();

  logic [3:0]  state;
  logic        illegal;
  logic [31:0] count;
  logic [3:0]  state4;
  logic        illegal4;
  logic [3:0]  count4;

  multicycle_control #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state       (state),
    .illegal     (illegal),
    .instr_count (count)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst         (rst4),
    .bus         (bus4),
    .state       (state4),
    .illegal     (illegal4),
    .instr_count (count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

  // Bit order: pc_write pc_write_cond pc_en i_or_d mem_read mem_write ir_write mem_to_reg
  //            reg_dst reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source[1:0]
  localparam logic [16:0] C_ZERO  = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_FETCH = 17'b1_0_1_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [16:0] C_FWAIT = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] C_ADDR  = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [16:0] C_MRD   = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [16:0] C_MWR   = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_EXEC  = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [16:0] C_RWB   = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [16:0] C_AWB   = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_00;
  localparam logic [16:0] C_BR1   = 17'b0_1_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] C_BR0   = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] C_JMP   = 17'b1_0_1_0_0_0_0_0_0_0_0_00_00_10;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic [3:0]  st;
    logic [16:0] ctl;
    int unsigned cnt;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [16:0] obs();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_en, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic [3:0] st,
                     input logic [16:0] ctl, input int unsigned cnt, input logic ill);
    vec_t v;
    v.op = op; v.z = z; v.st = st; v.ctl = ctl; v.cnt = cnt; v.ill = ill;
    vecs.push_back(v);
  endtask

  initial begin
    // lw: 0,1,2,3,4
    add(LW, 0, 0, C_FETCH, 0, 0);  add(LW, 0, 1, C_DEC, 0, 0);
    add(LW, 0, 2, C_ADDR, 0, 0);   add(LW, 0, 3, C_MRD, 0, 0);
    add(LW, 0, 4, C_MWB, 0, 0);
    // sw: 0,1,2,5
    add(SW, 0, 0, C_FETCH, 1, 0);  add(SW, 0, 1, C_DEC, 1, 0);
    add(SW, 0, 2, C_ADDR, 1, 0);   add(SW, 0, 5, C_MWR, 1, 0);
    // R-type: 0,1,6,7
    add(RT, 0, 0, C_FETCH, 2, 0);  add(RT, 0, 1, C_DEC, 2, 0);
    add(RT, 0, 6, C_EXEC, 2, 0);   add(RT, 0, 7, C_RWB, 2, 0);
    // addi: 0,1,10,11
    add(ADDI, 0, 0, C_FETCH, 3, 0); add(ADDI, 0, 1, C_DEC, 3, 0);
    add(ADDI, 0, 10, C_ADDR, 3, 0); add(ADDI, 0, 11, C_AWB, 3, 0);
    // beq taken, then not taken
    add(BEQ, 1, 0, C_FETCH, 4, 0); add(BEQ, 1, 1, C_DEC, 4, 0);
    add(BEQ, 1, 8, C_BR1, 4, 0);
    add(BEQ, 0, 0, C_FETCH, 5, 0); add(BEQ, 0, 1, C_DEC, 5, 0);
    add(BEQ, 0, 8, C_BR0, 5, 0);
    // j
    add(JMP, 0, 0, C_FETCH, 6, 0); add(JMP, 0, 1, C_DEC, 6, 0);
    add(JMP, 0, 9, C_JMP, 6, 0);
    // undefined opcode traps, not counted
    add(BAD, 0, 0, C_FETCH, 7, 0); add(BAD, 0, 1, C_DEC, 7, 0);
    add(BAD, 0, 15, C_ZERO, 7, 1);

    rst = 1'b0;
    rst4 = 1'b0;
    bus.opcode = RT;  bus.zero = 1'b0;  bus.mem_ready = 1'b1;
    bus4.opcode = JMP; bus4.zero = 1'b0; bus4.mem_ready = 1'b1;
    #12;
    chk("rst_state", 32'(state), 32'd14);
    chk("rst_ctrl", 32'(obs()), 32'(C_ZERO));
    chk("rst_count", count, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      bus.opcode = vecs[i].op;
      bus.zero   = vecs[i].z;
      step();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_ctrl", i), 32'(obs()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
    end

    // Trap holds regardless of inputs.
    bus.opcode = LW;
    bus.zero = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("trap_state", 32'(state), 32'd15);
      chk("trap_ctrl", 32'(obs()), 32'(C_ZERO));
      chk("trap_count", count, 32'd7);
      chk("trap_illegal", 32'(illegal), 32'd1);
    end

    // Reset mid-EXEC after one retired R-type.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    bus.opcode = RT;
    bus.zero = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_state", 32'(state), 32'd6);
    chk("pre_rst_count", count, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'd14);
    chk("midrst_ctrl", 32'(obs()), 32'(C_ZERO));
    chk("midrst_count", count, 32'd0);
    chk("midrst_illegal", 32'(illegal), 32'd0);
    #2;
    rst = 1'b1;
    step();
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_ctrl", 32'(obs()), 32'(C_FETCH));

    // Memory wait behaviour in FETCH.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    bus.mem_ready = 1'b0;
`ifdef MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fwait_state", 32'(state), 32'd0);
      chk("fwait_ctrl", 32'(obs()), 32'(C_FWAIT));
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("fdone_state", 32'(state), 32'd0);
    chk("fdone_ctrl", 32'(obs()), 32'(C_FETCH));
    step();
    chk("fdone_next", 32'(state), 32'd1);
`else
    step();
    chk("nowait_state", 32'(state), 32'd0);
    chk("nowait_ctrl", 32'(obs()), 32'(C_FETCH));
    step();
    chk("nowait_next", 32'(state), 32'd1);
    bus.mem_ready = 1'b1;
`endif

    // 4-bit counter wraps after 16 back-to-back jumps.
    rst4 = 1'b1;
    step();
    chk("w_fetch_state", 32'(state4), 32'd0);
    chk("w_fetch_count", 32'(count4), 32'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk("w_dec_state", 32'(state4), 32'd1);
      chk("w_dec_count", 32'(count4), 32'(k));
      step();
      chk("w_jmp_state", 32'(state4), 32'd9);
      chk("w_jmp_count", 32'(count4), 32'(k));
      step();
      chk("w_ret_state", 32'(state4), 32'd0);
      chk("w_ret_count", 32'(count4), 32'((k + 1) % 16));
    end
    chk("w_illegal", 32'(illegal4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
